// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic (read and write sides).
// Gray/binary conversions accept any pointer width up to MAX_PTR_WIDTH:
// callers zero-extend their pointer into the 32-bit argument and truncate
// the result back to their own width.
package fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int MAX_PTR_WIDTH      = 32;

  typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;

  function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the result unchanged
  function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(input logic [MAX_PTR_WIDTH-1:0] gray);
    logic [MAX_PTR_WIDTH-1:0] bin;
    bin[MAX_PTR_WIDTH-1] = gray[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Both stages clear to zero on reset; used by both FIFO sides.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1Q;
  logic [WIDTH-1:0] stage2Q;

  // Shift the foreign-domain value through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1Q <= '0;
      stage2Q <= '0;
    end else begin
      stage1Q <= d;
      stage2Q <= stage1Q;
    end
  end

  assign q = stage2Q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and empty controller for the async FIFO.
// Optional macro FIFO_RD_LEVEL_EN adds a registered occupancy count and a
// threshold-based almost-empty flag; without it rd_level is 0 and
// almost_empty mirrors empty.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
  parameter int ALMOST_EMPTY_THR = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wptr_gray_async,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic                  rd_underflow,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  almost_empty
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wq2Gray;
  logic [PW-1:0] rbinQ, rbinD;
  logic [PW-1:0] rgrayQ, rgrayD;
  logic          emptyQ, emptyD;
  logic          underflowQ, underflowD;
  logic          rdFire;

  sync_2ff #(
    .WIDTH(PW)
  ) u_wptr_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (wptr_gray_async),
    .q    (wq2Gray)
  );

  // Next pointer: advance only on an accepted read; empty looks at the pointer we are about to hold
  always_comb begin
    rdFire     = rd_en & ~emptyQ;
    rbinD      = rbinQ + {{ADDR_WIDTH{1'b0}}, rdFire};
    rgrayD     = PW'(bin2gray(32'(rbinD)));
    emptyD     = (rgrayD == wq2Gray);
    underflowD = rd_en & emptyQ;
  end

  // Pointer, empty and underflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbinQ      <= '0;
      rgrayQ     <= '0;
      emptyQ     <= 1'b1;
      underflowQ <= 1'b0;
    end else begin
      rbinQ      <= rbinD;
      rgrayQ     <= rgrayD;
      emptyQ     <= emptyD;
      underflowQ <= underflowD;
    end
  end

  assign raddr        = rbinQ[ADDR_WIDTH-1:0];
  assign rptr_gray    = rgrayQ;
  assign empty        = emptyQ;
  assign rd_underflow = underflowQ;

`ifdef FIFO_RD_LEVEL_EN
  localparam logic [PW-1:0] THR = PW'(ALMOST_EMPTY_THR);

  logic [PW-1:0] wq2Bin;
  logic [PW-1:0] levelQ, levelD;
  logic          almostQ, almostD;

  // Occupancy as seen against the synchronized write pointer, modulo the pointer range
  always_comb begin
    wq2Bin  = PW'(gray2bin(32'(wq2Gray)));
    levelD  = wq2Bin - rbinD;
    almostD = (levelD <= THR);
  end

  // Level and almost-empty registers; reset reflects an empty FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      levelQ  <= '0;
      almostQ <= 1'b1;
    end else begin
      levelQ  <= levelD;
      almostQ <= almostD;
    end
  end

  assign rd_level     = levelQ;
  assign almost_empty = almostQ;
`else
  logic unusedThr;
  assign unusedThr    = (ALMOST_EMPTY_THR != 0);
  assign rd_level     = '0;
  assign almost_empty = emptyQ;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed fill/drain, underflow and
// async-reset checks followed by randomized reads and write-pointer moves,
// all compared against a FIFO occupancy model.
module tb_fifo_rd_ctrl;

  localparam int AW   = 4;
  localparam int PW   = AW + 1;
  localparam int MOD  = 1 << PW;
  localparam int DEP  = 1 << AW;
  localparam int THR  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en;
  logic [PW-1:0] wptr_gray_async;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr_gray;
  logic          empty;
  logic          rd_underflow;
  logic [PW-1:0] rd_level;
  logic          almost_empty;

  int errors = 0;
  int checks = 0;

  // Reference state: read count, write count, and write values as the read side has sampled them
  int mRbin;
  int wBin;
  bit mEmpty;
  bit mUnder;
  int mLevel;
  bit mAlmost;
  int wHist[$];

  fifo_rd_ctrl #(
    .ADDR_WIDTH      (AW),
    .ALMOST_EMPTY_THR(THR)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_en          (rd_en),
    .wptr_gray_async(wptr_gray_async),
    .raddr          (raddr),
    .rptr_gray      (rptr_gray),
    .empty          (empty),
    .rd_underflow   (rd_underflow),
    .rd_level       (rd_level),
    .almost_empty   (almost_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] toGray(input int b);
    logic [PW-1:0] v;
    v = b[PW-1:0];
    return v ^ (v >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mRbin   = 0;
    wBin    = 0;
    mEmpty  = 1'b1;
    mUnder  = 1'b0;
    mLevel  = 0;
    mAlmost = 1'b1;
    wHist.delete();
    wHist.push_back(0);
    wHist.push_back(0);
  endtask

  // One rising edge of the model: the read side sees the write pointer sampled two edges ago
  task automatic modelEdge();
    int  wSeen;
    bit  accept;
    wSeen   = wHist[wHist.size() - 2];
    accept  = rd_en && !mEmpty;
    mUnder  = rd_en && mEmpty;
    mRbin   = (mRbin + (accept ? 1 : 0)) % MOD;
    mEmpty  = (mRbin == wSeen);
    mLevel  = (wSeen - mRbin + MOD) % MOD;
    mAlmost = (mLevel <= THR);
    wHist.push_back(wBin);
    if (wHist.size() > 4) void'(wHist.pop_front());
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".raddr"}, 32'(raddr), 32'(mRbin % DEP));
    checkOutput({tag, ".rptr_gray"}, 32'(rptr_gray), 32'(toGray(mRbin)));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(mEmpty));
    checkOutput({tag, ".rd_underflow"}, 32'(rd_underflow), 32'(mUnder));
`ifdef FIFO_RD_LEVEL_EN
    checkOutput({tag, ".rd_level"}, 32'(rd_level), 32'(mLevel));
    checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'(mAlmost));
`else
    checkOutput({tag, ".rd_level"}, 32'(rd_level), 32'd0);
    checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'(mEmpty));
`endif
  endtask

  // Drive inputs at the falling edge, step one rising edge, then compare at the next falling edge
  task automatic applyStimulus(input bit rd, input int wb, input string tag);
    rd_en           = rd;
    wBin            = wb % MOD;
    wptr_gray_async = toGray(wBin);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic doReset();
    rst_n           = 1'b0;
    rd_en           = 1'b0;
    wptr_gray_async = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    rd_en           = 1'b0;
    wptr_gray_async = '0;
    @(negedge clk);
    doReset();

    // Fill to three entries; empty must stay up for two edges and drop on the third
    applyStimulus(1'b0, 3, "fill1");
    checkOutput("fillEmpty1", 32'(empty), 32'd1);
    applyStimulus(1'b0, 3, "fill2");
    checkOutput("fillEmpty2", 32'(empty), 32'd1);
    applyStimulus(1'b0, 3, "fill3");
    checkOutput("fillEmpty3", 32'(empty), 32'd0);
    checkOutput("drainAddr0", 32'(raddr), 32'd0);

    // Drain: addresses step 1,2,3, gray 1,3,2, empty on the third accepted read
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3, "drain");
      checkOutput("drainAddr", 32'(raddr), 32'(i + 1));
    end
    checkOutput("drainGray", 32'(rptr_gray), 32'd2);
    checkOutput("drainEmpty", 32'(empty), 32'd1);

    // Reads while empty: pointer frozen, underflow held for each requesting cycle
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3, "under");
      checkOutput("underFlag", 32'(rd_underflow), 32'd1);
      checkOutput("underAddr", 32'(raddr), 32'd3);
    end
    applyStimulus(1'b0, 3, "underEnd");
    checkOutput("underClear", 32'(rd_underflow), 32'd0);

    // Randomized traffic; write pointer moves at most one step per cycle and never overfills
    for (int n = 0; n < 3000; n++) begin
      int nextW;
      nextW = wBin;
      if (((wBin - mRbin + MOD) % MOD) < DEP && $urandom_range(0, 99) < 45) nextW = (wBin + 1) % MOD;
      applyStimulus($urandom_range(0, 99) < 55, nextW, "rand");
    end

    // Async reset mid-run: outputs clear before any further rising edge
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, (wBin + 1) % MOD, "preRst");
    applyStimulus(1'b1, wBin, "preRst");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRst.empty", 32'(empty), 32'd1);
    checkOutput("asyncRst.raddr", 32'(raddr), 32'd0);
    checkOutput("asyncRst.gray", 32'(rptr_gray), 32'd0);
    checkOutput("asyncRst.under", 32'(rd_underflow), 32'd0);
    @(negedge clk);
    doReset();

    // First accepted read after reset comes from address 0
    applyStimulus(1'b0, 2, "post");
    applyStimulus(1'b0, 2, "post");
    applyStimulus(1'b0, 2, "post");
    checkOutput("postAddr", 32'(raddr), 32'd0);
    applyStimulus(1'b1, 2, "post");
    checkOutput("postRead", 32'(raddr), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side pointer and empty controller for the async FIFO. It sits in the read clock domain, opposite the write-side pointer and full logic.
- Synchronizes the write-domain Gray pointer.
- Advances the read pointer on accepted reads.
- Drives the RAM read address.
- Exports its own Gray pointer back to the write domain.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
ALMOST_EMPTY_THR, 2, almost-empty threshold in entries (used only with the optional feature).

Ports:
clk  input  1  read-domain clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
rd_en  input  1  consumer read request.
wptr_gray_async  input  ADDR_WIDTH+1  write pointer in Gray code, from the write domain (unsynchronized).
raddr  output  ADDR_WIDTH  RAM read address = rbin[ADDR_WIDTH-1:0].
rptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, to the write domain.
empty  output  1  registered FIFO-empty flag.
rd_underflow  output  1  one-cycle pulse: rd_en sampled while empty.
rd_level  output  ADDR_WIDTH+1  occupancy seen by the read side (feature-dependent).
almost_empty  output  1  rd_level <= ALMOST_EMPTY_THR (feature-dependent).

Behaviour:
- Reset (async assert, no clock needed):
  - rbin=0, rptr_gray=0, raddr=0.
  - Both sync stages=0.
  - empty=1, rd_underflow=0, rd_level=0, almost_empty=1.
- Synchronizer: wptr_gray_async -> two flops -> wq2_gray. No combinational path from wptr_gray_async to any output.
- rd_fire = rd_en & ~empty. Only rd_fire advances the pointer.
- Next-state arithmetic:
  - rbin_next = rbin + rd_fire, modulo 2**(ADDR_WIDTH+1).
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
- Every edge: rbin<=rbin_next; rptr_gray<=rgray_next; empty<=(rgray_next == wq2_gray).
- Latency:
  - Read: raddr reflects the new rbin one cycle after rd_fire. The RAM data for the accepted read is addressed in the cycle rd_fire is high.
  - Empty deassert: a wptr_gray_async change stable before edge N gives wq2 updated at edge N+1 and empty updated at edge N+2. Empty therefore deasserts no earlier than 3 edges after the write-side update.
  - Empty assert on the last read: the same edge as the last rd_fire. No extra read is ever accepted.
- rd_en while empty:
  - No pointer change.
  - rd_underflow=1 for exactly that cycle (registered, visible after the edge).
- Wrap-around: rbin 2**(ADDR_WIDTH+1)-1 -> 0; raddr wraps to 0; Gray MSB toggles per lap.
- Simultaneous read of the last entry and arrival of a new wq2: empty compares rgray_next against the current wq2. This is conservative and correct.
- Reset mid-operation: all state is cleared immediately. The first accepted read after release is at raddr=0.

Optional Feature:
Macro FIFO_RD_LEVEL_EN.
- Defined:
  - wq2_bin = gray2bin(wq2_gray).
  - rd_level registered = wq2_bin - rbin_next, modulo 2**(ADDR_WIDTH+1).
  - almost_empty registered = (that value <= ALMOST_EMPTY_THR).
- Undefined:
  - rd_level tied to 0, almost_empty tied to empty.
  - No gray2bin logic is synthesized.

Decomposition:
- Package fifo_pkg:
  - bin2gray and gray2bin functions, parameterized by width.
  - Constant DEFAULT_ADDR_WIDTH=4.
  - Typedef for the pointer vector at the default width.
- Sub-module sync_2ff:
  - Parameter WIDTH.
  - Ports clk, rst_n, d, q.
  - Reset-to-0 flop pair, reused by the write side.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> empty=1, raddr=0, rptr_gray=0, rd_underflow=0. Asserting rst_n mid-run clears outputs before the next clk edge.
- Fill then drain, ADDR_WIDTH=4:
  - Stimulus: set wptr_gray_async=5'b00010 (bin 3); empty falls on the 3rd rising edge; then hold rd_en=1.
  - raddr sequence 0,1,2,3 and rptr_gray sequence 0,1,3,2.
  - empty=1 after the 3rd accepted read; rd_underflow pulses on the 4th request.
- Underflow: rd_en=1 with empty=1 for 3 cycles -> rbin unchanged, rd_underflow=1 for each of those 3 cycles.
- Wrap:
  - Set rbin to 31 via prior reads and wptr=bin 1 (gray 5'b00001).
  - Read 2 entries -> rptr_gray 5'b10000 -> 5'b00000 -> 5'b00001, raddr 15 -> 0 -> 1, then empty=1.
- Write-pointer latency: toggle wptr_gray_async between edges -> empty changes exactly 2 edges after the first sampling edge, never combinationally.
- FIFO_RD_LEVEL_EN defined:
  - wptr=bin 10, rbin=4 -> rd_level=6, almost_empty=0.
  - After 4 more reads -> rd_level=2, almost_empty=1.
  - Macro undefined -> rd_level=0 and almost_empty==empty always.
